// File: rtl/diad_trace_if.sv
// rtl/diad_trace_if.sv - read-out stream bundle carried from diad_trace to its consumer
interface diad_trace_if #(
  parameter int DATA_W = 168
);
  logic              ow_rd_valid;
  logic              iw_rd_ready;
  logic [DATA_W-1:0] ow_rd_data;
  logic              ow_rd_last;

  modport master (
    output ow_rd_valid,
    output ow_rd_data,
    output ow_rd_last,
    input  iw_rd_ready
  );

  modport slave (
    input  ow_rd_valid,
    input  ow_rd_data,
    input  ow_rd_last,
    output iw_rd_ready
  );
endinterface

// File: rtl/diad_trace.sv
// rtl/diad_trace.sv - pipeline trace capture: circular buffer, trigger + post window, oldest-first readout
// Define TRACE_TICK_EN to append a free-running 32-bit cycle stamp to every stored entry.
module diad_trace #(
  parameter int CH_W     = 24,
  parameter int N_CH     = 7,
  parameter int DEPTH    = 64,
  parameter int POST_CNT = 16,
  localparam int SW      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic [N_CH*CH_W-1:0] iw_ch,
  input  logic                 iw_sample_en,
  input  logic                 iw_arm,
  input  logic                 iw_abort,
  input  logic [SW-1:0]        iw_trig_sel,
  input  logic [CH_W-1:0]      iw_trig_val,
  diad_trace_if.master         rd,
  output logic [1:0]           ow_state,
  output logic [AW:0]          ow_fill
);

`ifdef TRACE_TICK_EN
  localparam int DW = N_CH*CH_W + 32;
`else
  localparam int DW = N_CH*CH_W;
`endif

  localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LOAD = AW'(POST_CNT);
  localparam bit            NO_POST   = (POST_CNT == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fill_q;
  logic [AW:0]   remain_q;
  logic [AW-1:0] post_q;
  logic          valid_q;
  logic          last_q;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wdata;

  logic          trig_hit;
  logic          sample_ok;
  logic          fin;
  logic [AW-1:0] wr_ptr_d;
  logic [AW:0]   fill_d;
  logic [AW-1:0] rd_start;

`ifdef TRACE_TICK_EN
  logic [31:0] tick_q;

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 32'd1;
    end
  end

  assign wdata = {tick_q, iw_ch};
`else
  assign wdata = iw_ch;
`endif

  // An out-of-range select matches no loop index, so it can never trigger.
  always_comb begin
    trig_hit = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (iw_trig_sel == SW'(k) && iw_ch[k*CH_W +: CH_W] == iw_trig_val) begin
        trig_hit = 1'b1;
      end
    end
  end

  always_comb begin
    sample_ok = iw_sample_en && !iw_abort && !iw_arm &&
                (state_q == ST_PRE || state_q == ST_POST);
    wr_ptr_d  = wr_ptr_q + 1'b1;
    fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    rd_start  = (fill_d < FILL_MAX) ? '0 : wr_ptr_d;
    fin       = sample_ok &&
                ((state_q == ST_PRE  && trig_hit && NO_POST) ||
                 (state_q == ST_POST && post_q == AW'(1)));
  end

  always_ff @(posedge iw_clk) begin
    if (sample_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      remain_q <= '0;
      post_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else if (iw_abort || iw_arm) begin
      state_q  <= iw_abort ? ST_IDLE : ST_PRE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      remain_q <= '0;
      post_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_PRE, ST_POST: begin
          if (sample_ok) begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            if (state_q == ST_PRE && trig_hit) begin
              post_q  <= POST_LOAD;
              state_q <= ST_POST;
            end else if (state_q == ST_POST) begin
              post_q <= post_q - 1'b1;
            end
            // Last write of the window: the oldest surviving entry sits at 0 until the ring wraps.
            if (fin) begin
              state_q  <= ST_DONE;
              rd_ptr_q <= rd_start;
              remain_q <= fill_d;
              valid_q  <= 1'b1;
              last_q   <= (fill_d == (AW+1)'(1));
            end
          end
        end
        ST_DONE: begin
          if (valid_q && rd.iw_rd_ready) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            last_q   <= (remain_q == (AW+1)'(2));
            if (remain_q == (AW+1)'(1)) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd.ow_rd_valid = valid_q;
  assign rd.ow_rd_last  = last_q;
  assign rd.ow_rd_data  = valid_q ? mem[rd_ptr_q] : '0;
  assign ow_state       = state_q;
  assign ow_fill        = fill_q;

endmodule

// File: tb/tb_diad_trace.sv
// tb/tb_diad_trace.sv - randomized self-checking bench for diad_trace against a queue-based capture model
module tb_diad_trace;
  localparam int CH_W     = 8;
  localparam int N_CH     = 2;
  localparam int DEPTH    = 8;
  localparam int POST_CNT = 3;
`ifdef TRACE_TICK_EN
  localparam int DW = N_CH*CH_W + 32;
`else
  localparam int DW = N_CH*CH_W;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ch = '0;
  logic        sample_en = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig_sel = 1'b0;
  logic [7:0]  trig_val = '0;
  logic [1:0]  state;
  logic [3:0]  fill;

  diad_trace_if #(.DATA_W(DW)) rd_if ();

  diad_trace #(
    .CH_W(CH_W), .N_CH(N_CH), .DEPTH(DEPTH), .POST_CNT(POST_CNT)
  ) dut (
    .iw_clk(clk), .iw_rst(rst_n), .iw_ch(ch), .iw_sample_en(sample_en),
    .iw_arm(arm), .iw_abort(abort), .iw_trig_sel(trig_sel), .iw_trig_val(trig_val),
    .rd(rd_if), .ow_state(state), .ow_fill(fill)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  s_c0[$];
  logic [7:0]  s_c1[$];
  bit          s_en[$];
  logic [15:0] exp_q[$];
  int          done_idx;
  bit          tick_chk = 1'b0;

  // Reference: every sampled value since arm is logged; the window ends POST_CNT samples after the
  // first match, and the readout is the newest DEPTH of the log.
  task automatic build_expected(input bit sel, input logic [7:0] tv);
    logic [15:0] written[$];
    bit          triggered = 1'b0;
    int          left = 0;
    int          first;
    done_idx = -1;
    exp_q.delete();
    for (int i = 0; i < s_c0.size(); i++) begin
      if (s_en[i]) begin
        written.push_back({s_c1[i], s_c0[i]});
        if (!triggered) begin
          if ((sel ? s_c1[i] : s_c0[i]) == tv) begin
            triggered = 1'b1;
            left = POST_CNT;
            if (left == 0) begin done_idx = i; break; end
          end
        end else begin
          left = left - 1;
          if (left == 0) begin done_idx = i; break; end
        end
      end
    end
    first = (written.size() > DEPTH) ? written.size() - DEPTH : 0;
    for (int j = first; j < written.size(); j++) exp_q.push_back(written[j]);
  endtask

  task automatic clear_stim();
    s_c0.delete(); s_c1.delete(); s_en.delete();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic run_capture(input bit sel, input logic [7:0] tv, input string name);
    build_expected(sel, tv);
    trig_sel = sel;
    trig_val = tv;
    pulse_arm();
    n_total++;
    if (state !== 2'd1) $display("FAIL %s arm_state: got %0d want 1", name, state);
    else n_pass++;
    if (done_idx < 0) begin
      n_total++;
      $display("FAIL %s stimulus_no_trigger: got -1 want >=0", name);
      return;
    end
    for (int i = 0; i <= done_idx; i++) begin
      ch = {s_c1[i], s_c0[i]};
      sample_en = s_en[i];
      @(posedge clk); #1;
    end
    sample_en = 1'b0;
    n_total++;
    if (state !== 2'd3) $display("FAIL %s done_state: got %0d want 3", name, state);
    else n_pass++;
    n_total++;
    if (fill !== 4'(exp_q.size())) $display("FAIL %s fill: got %0d want %0d", name, fill, exp_q.size());
    else n_pass++;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic readout(input int mode, input string name, input int stop_after);
    int          idx = 0;
    int          cyc = 0;
    logic [DW-1:0] prev = '0;
    bit          prev_stall = 1'b0;
    logic        r;
    logic [31:0] prev_tick = '0;
    bit          have_tick = 1'b0;
    while (idx < exp_q.size() && cyc < 200) begin
      if (stop_after >= 0 && idx == stop_after) return;
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      rd_if.iw_rd_ready = r;
      n_total++;
      if (rd_if.ow_rd_valid !== 1'b1) $display("FAIL %s valid[%0d]: got %b want 1", name, idx, rd_if.ow_rd_valid);
      else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (rd_if.ow_rd_data !== prev) $display("FAIL %s stall_hold[%0d]: got %h want %h", name, idx, rd_if.ow_rd_data, prev);
        else n_pass++;
      end
      n_total++;
      if (rd_if.ow_rd_data[15:0] !== exp_q[idx]) $display("FAIL %s data[%0d]: got %h want %h", name, idx, rd_if.ow_rd_data[15:0], exp_q[idx]);
      else n_pass++;
      n_total++;
      if (rd_if.ow_rd_last !== (idx == exp_q.size() - 1)) $display("FAIL %s last[%0d]: got %b want %b", name, idx, rd_if.ow_rd_last, (idx == exp_q.size() - 1));
      else n_pass++;
`ifdef TRACE_TICK_EN
      if (tick_chk && r) begin
        if (have_tick) begin
          n_total++;
          if (rd_if.ow_rd_data[DW-1:16] !== prev_tick + 32'd1) $display("FAIL %s tick[%0d]: got %0d want %0d", name, idx, rd_if.ow_rd_data[DW-1:16], prev_tick + 32'd1);
          else n_pass++;
        end
        prev_tick = rd_if.ow_rd_data[DW-1:16];
        have_tick = 1'b1;
      end
`endif
      prev = rd_if.ow_rd_data;
      prev_stall = !r;
      if (r) idx++;
      cyc++;
      @(posedge clk); #1;
    end
    rd_if.iw_rd_ready = 1'b0;
    n_total++;
    if (idx != exp_q.size()) $display("FAIL %s delivered: got %0d want %0d", name, idx, exp_q.size());
    else n_pass++;
    n_total++;
    if (rd_if.ow_rd_valid !== 1'b0 || state !== 2'd0) $display("FAIL %s end: got valid=%b state=%0d want valid=0 state=0", name, rd_if.ow_rd_valid, state);
    else n_pass++;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if (state !== 2'd0 || fill !== 4'd0 || rd_if.ow_rd_valid !== 1'b0 || rd_if.ow_rd_last !== 1'b0 || rd_if.ow_rd_data !== '0)
      $display("FAIL reset_values: got state=%0d fill=%0d valid=%b want 0 0 0", state, fill, rd_if.ow_rd_valid);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    trig_sel = 1'b0;
    trig_val = 8'd1;
    pulse_arm();
    sample_en = 1'b1;
    ch = 16'h0001;
    @(posedge clk); #1;
    ch = 16'h0002;
    @(posedge clk); #1;
    sample_en = 1'b0;
    n_total++;
    if (state !== 2'd2 || fill !== 4'd2) $display("FAIL mid_post_setup: got state=%0d fill=%0d want 2 2", state, fill);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (state !== 2'd0 || fill !== 4'd0 || rd_if.ow_rd_valid !== 1'b0)
      $display("FAIL async_reset: got state=%0d fill=%0d valid=%b want 0 0 0", state, fill, rd_if.ow_rd_valid);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_stim();
    for (int i = 1; i <= 5; i++) begin
      s_c0.push_back(8'(i)); s_c1.push_back(8'($urandom)); s_en.push_back(1'b1);
    end
    run_capture(1'b0, 8'd2, "basic");
    tick_chk = 1'b1;
    readout(0, "basic", -1);
    tick_chk = 1'b0;
  endtask

  task automatic test_wrap();
    clear_stim();
    for (int i = 1; i <= 20; i++) begin
      s_c0.push_back(8'(i)); s_c1.push_back(8'($urandom)); s_en.push_back(1'b1);
    end
    run_capture(1'b0, 8'd15, "wrap");
    readout(0, "wrap", -1);
  endtask

  task automatic test_stall();
    clear_stim();
    for (int i = 1; i <= 12; i++) begin
      s_c0.push_back(8'(i)); s_c1.push_back(8'($urandom)); s_en.push_back(1'b1);
    end
    run_capture(1'b0, 8'd6, "stall");
    readout(1, "stall", -1);
  endtask

  task automatic test_sparse_post();
    logic [7:0] c0_tab [9] = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd4, 8'd11, 8'd5, 8'd12, 8'd6};
    bit         en_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_stim();
    for (int i = 0; i < 9; i++) begin
      s_c0.push_back(c0_tab[i]); s_c1.push_back(8'($urandom)); s_en.push_back(en_tab[i]);
    end
    run_capture(1'b0, 8'd3, "sparse");
    readout(0, "sparse", -1);
  endtask

  task automatic test_random();
    int len, p;
    bit sel;
    for (int it = 0; it < 4; it++) begin
      clear_stim();
      len = $urandom_range(2, 20);
      for (int i = 0; i < len; i++) begin
        s_c0.push_back(8'($urandom)); s_c1.push_back(8'($urandom)); s_en.push_back($urandom_range(0, 3) != 0);
      end
      p = $urandom_range(0, len - 1);
      s_en[p] = 1'b1;
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        s_c0.push_back(8'($urandom)); s_c1.push_back(8'($urandom)); s_en.push_back(1'b1);
      end
      run_capture(sel, sel ? s_c1[p] : s_c0[p], "random");
      readout(2, "random", -1);
    end
  endtask

  task automatic test_arm_abort();
    clear_stim();
    for (int i = 1; i <= 6; i++) begin
      s_c0.push_back(8'(i)); s_c1.push_back(8'd0); s_en.push_back(1'b1);
    end
    run_capture(1'b0, 8'd1, "arm_mid");
    readout(0, "arm_mid", 2);
    rd_if.iw_rd_ready = 1'b0;
    pulse_arm();
    n_total++;
    if (state !== 2'd1 || fill !== 4'd0 || rd_if.ow_rd_valid !== 1'b0)
      $display("FAIL arm_mid_readout: got state=%0d fill=%0d valid=%b want 1 0 0", state, fill, rd_if.ow_rd_valid);
    else n_pass++;
    arm = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    abort = 1'b0;
    n_total++;
    if (state !== 2'd0 || fill !== 4'd0) $display("FAIL arm_abort_same: got state=%0d fill=%0d want 0 0", state, fill);
    else n_pass++;
    ch = 16'h0007;
    trig_val = 8'd7;
    sample_en = 1'b1;
    pulse_arm();
    sample_en = 1'b0;
    n_total++;
    if (state !== 2'd1 || fill !== 4'd0) $display("FAIL arm_with_trigger: got state=%0d fill=%0d want 1 0", state, fill);
    else n_pass++;
    trig_val = 8'd99;
    sample_en = 1'b1;
    ch = 16'h0003;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_total++;
    if (state !== 2'd0 || fill !== 4'd0) $display("FAIL abort_pre: got state=%0d fill=%0d want 0 0", state, fill);
    else n_pass++;
  endtask

  initial begin
    rd_if.iw_rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_sparse_post();
    test_random();
    test_arm_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/diad_trace.md
Name: diad_trace

Overview:
- Synthesizable, parametrised pipeline trace capture unit for the diad core.
- Samples N_CH per-stage channels every enabled cycle (PC, instr, result, ...) into a circular buffer.
- Freezes on a programmable trigger after POST_CNT further samples, then streams the captured window out oldest-first over a valid/ready port.
- Replaces ad-hoc simulation $display tracing with on-chip capture usable in silicon and in the bench.

Parameters:
- CH_W, 24, width of one channel in bits.
- N_CH, 7, number of channels captured per sample (IA, IAIF, IFID, IDEX, EXMA, MAMO, MOWB).
- DEPTH, 64, buffer entries; power of two, >= 4.
- POST_CNT, 16, samples stored after the trigger sample; must satisfy 0 <= POST_CNT < DEPTH.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  reset, asynchronous, active-low.
- iw_ch  in  N_CH*CH_W  channel snapshot; channel k occupies bits [k*CH_W +: CH_W].
- iw_sample_en  in  1  capture the snapshot this cycle (pipeline not stalled).
- iw_arm  in  1  pulse: clear the buffer and begin capture.
- iw_abort  in  1  pulse: return to IDLE.
- iw_trig_sel  in  $clog2(N_CH)  channel compared for the trigger.
- iw_trig_val  in  CH_W  trigger match value.
- ow_rd_valid  out  1  read entry available.
- iw_rd_ready  in  1  consumer accepts the entry.
- ow_rd_data  out  N_CH*CH_W (+32 with the optional feature)  entry payload.
- ow_rd_last  out  1  current entry is the final one.
- ow_state  out  2  IDLE=0, PRE=1, POST=2, DONE=3.
- ow_fill  out  $clog2(DEPTH)+1  valid entries held, saturating at DEPTH.

Behaviour:
- Reset (iw_rst=0, asynchronous): state IDLE; write and read pointers 0; fill 0; post counter 0; all outputs 0. Buffer contents are don't-care.
- IDLE: no sampling. iw_arm -> PRE next cycle; pointers and fill cleared.
- PRE: each cycle with iw_sample_en writes iw_ch at wr_ptr, wr_ptr+1 mod DEPTH, fill+1 saturating at DEPTH.
- Trigger in PRE: iw_sample_en=1 and channel[iw_trig_sel]==iw_trig_val. The trigger sample is written; post counter loads POST_CNT.
  - POST_CNT==0 -> DONE next cycle.
  - Otherwise -> POST.
- POST: each sampled cycle writes an entry and decrements the counter. The write that brings the counter to 0 -> DONE next cycle. Trigger matches in POST are ignored.
- Wrap-around: in PRE/POST, overwriting when fill==DEPTH is normal; the oldest entry is lost.
- DONE entry: rd_ptr = (fill<DEPTH) ? 0 : wr_ptr; remaining = fill.
- DONE readout:
  - ow_rd_valid=1 while remaining>0.
  - ow_rd_data = buffer[rd_ptr], combinational from rd_ptr.
  - ow_rd_last=1 when remaining==1.
  - On valid&&ready: rd_ptr+1 mod DEPTH, remaining-1. Data must not change while valid is high and ready is low.
  - After the last handshake -> IDLE next cycle; ow_rd_valid drops the same cycle.
- Empty capture: fill==0 cannot reach DONE, because the trigger always writes one entry.
- iw_arm in DONE: aborts readout -> PRE with a cleared buffer. iw_arm in PRE/POST: restarts PRE and clears the buffer.
- iw_abort: any state -> IDLE next cycle; outputs return to reset values except buffer contents. iw_abort wins over a simultaneous iw_arm.
- iw_arm and trigger in the same IDLE cycle: arm wins; no sample is taken.
- ow_fill is reported in all states. In DONE it shows the captured count and does not decrement during readout.
- iw_trig_sel >= N_CH: the trigger never matches.

Optional Feature:
- Macro TRACE_TICK_EN.
- Defined:
  - A free-running 32-bit cycle counter runs from reset and wraps at 2^32.
  - Each stored entry appends the counter value at write time in the top 32 bits of ow_rd_data.
  - Payload width becomes N_CH*CH_W+32.
- Undefined: no counter, and payload width is N_CH*CH_W.

Test Plan (bench uses CH_W=8, N_CH=2, DEPTH=8, POST_CNT=3):
- Reset mid-POST (iw_rst low for 1 cycle) -> ow_state=0, ow_fill=0, ow_rd_valid=0 immediately, without waiting for a clock edge.
- Arm; sample ch0=1..5 every cycle; trigger on ch0==2 -> DONE after the sample with ch0=5. Readout gives ch0 = 1,2,3,4,5 with ow_rd_last on 5, ow_fill=5.
- Arm; sample ch0=1..20; trigger on ch0==15 -> DONE after ch0=18. Readout gives 11..18 (8 entries, wrapped), ow_fill=8.
- Readout with iw_rd_ready toggling 1,0,0,1,... -> every entry is delivered exactly once, in order, and data is held stable while stalled.
- iw_sample_en low on alternate cycles in POST -> exactly 3 post entries are stored; unsampled values are absent from the readout.
- iw_arm mid-readout -> state PRE, fill 0. Simultaneous iw_arm and iw_abort -> IDLE. With TRACE_TICK_EN defined -> tick fields increase by 1 between back-to-back samples.
